// File: rtl/conv_row_product_gen.sv
// Convolution row-product generator: 3-tap signed dot product per row on one shared multiplier.
// Optional CONV_ROW_SATURATE_EN: saturating accumulation plus a sticky sat_flag output.
module conv_row_product_gen #(
   parameter int DATA_W = 8,
   parameter int OUT_W  = 16,
   parameter int ROWS   = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     w_load,
   input  logic [3*DATA_W-1:0]      w_in,
   input  logic                     start,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     in_ready,
   output logic signed [OUT_W-1:0]  sum,
   output logic                     load,
   output logic                     window_done,
`ifdef CONV_ROW_SATURATE_EN
   output logic                     sat_flag,
`endif
   output logic                     busy
);

   localparam int ROW_W = 4;
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

   typedef enum logic [1:0] {IDLE, ACC, EMIT} state_t;

   state_t                    state_reg, state_next;
   logic [1:0]                tap_reg;
   logic [ROW_W-1:0]          row_reg;
   logic signed [OUT_W-1:0]   acc_reg;
   logic signed [DATA_W-1:0]  w_reg [3];
   logic signed [DATA_W-1:0]  w_unpacked [3];
   logic signed [DATA_W-1:0]  w_sel;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [OUT_W-1:0]   prod_ext;
   logic signed [OUT_W-1:0]   acc_add;
   logic                      clip;
   logic                      last_row;
   logic                      accept;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_wsplit
         assign w_unpacked[gi] = w_in[gi*DATA_W +: DATA_W];
      end
   endgenerate

   assign last_row = (row_reg == LAST_ROW);
   assign accept   = in_valid && (state_reg == ACC);

   // One multiplier shared across taps; the tap counter selects the weight.
   always_comb begin
      w_sel = w_reg[0];
      case (tap_reg)
         2'd1:    w_sel = w_reg[1];
         2'd2:    w_sel = w_reg[2];
         default: w_sel = w_reg[0];
      endcase
   end

   assign prod     = in_data * w_sel;
   assign prod_ext = OUT_W'(prod);

`ifdef CONV_ROW_SATURATE_EN
   localparam logic signed [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic signed [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
   logic signed [OUT_W:0] wide_sum;

   // One guard bit: overflow shows up as the top two bits disagreeing.
   assign wide_sum = {acc_reg[OUT_W-1], acc_reg} + {prod_ext[OUT_W-1], prod_ext};
   assign clip     = (wide_sum[OUT_W] != wide_sum[OUT_W-1]);
   assign acc_add  = clip ? (wide_sum[OUT_W] ? SAT_MIN : SAT_MAX) : wide_sum[OUT_W-1:0];
`else
   assign clip    = 1'b0;
   assign acc_add = acc_reg + prod_ext;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      in_ready    = 1'b0;
      load        = 1'b0;
      window_done = 1'b0;
      busy        = (state_reg != IDLE);
      case (state_reg)
         IDLE: begin
            if (start) state_next = ACC;
         end
         ACC: begin
            in_ready = 1'b1;
            if (in_valid && tap_reg == 2'd2) state_next = EMIT;
         end
         EMIT: begin
            load        = 1'b1;
            window_done = last_row;
            state_next  = last_row ? IDLE : ACC;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tap_reg <= '0;
         row_reg <= '0;
         acc_reg <= '0;
         sum     <= '0;
         for (int i = 0; i < 3; i++) w_reg[i] <= '0;
`ifdef CONV_ROW_SATURATE_EN
         sat_flag <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (w_load) begin
                  for (int i = 0; i < 3; i++) w_reg[i] <= w_unpacked[i];
               end
               if (start) begin
                  tap_reg <= '0;
                  row_reg <= '0;
                  acc_reg <= '0;
`ifdef CONV_ROW_SATURATE_EN
                  sat_flag <= 1'b0;
`endif
               end
            end
            ACC: begin
               if (accept) begin
                  acc_reg <= acc_add;
                  tap_reg <= tap_reg + 2'd1;
                  // Final tap lands straight in sum so it is valid during EMIT.
                  if (tap_reg == 2'd2) sum <= acc_add;
`ifdef CONV_ROW_SATURATE_EN
                  if (clip) sat_flag <= 1'b1;
`endif
               end
            end
            EMIT: begin
               acc_reg <= '0;
               tap_reg <= '0;
               row_reg <= last_row ? '0 : row_reg + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
